// File: rtl/venturi_pcie_pkg.sv
// Shared PCIe requester definitions: request type codes, page geometry, completion status
// and the DMA read requester FSM encoding.
package venturi_pcie_pkg;

    localparam logic [3:0]  RQ_TYPE_MRD   = 4'b0000;
    localparam int unsigned PAGE_DW       = 1024;
    localparam logic [2:0]  CPL_STATUS_SC = 3'd0;

    typedef enum logic [1:0] {
        StIdle,
        StAlloc,
        StIssue,
        StDrain
    } rd_state_e;

    // MRRS code to DWORDs: 0 -> 32 DW (128 B) .. 5 -> 1024 DW (4 KB); 6 and 7 saturate at 5.
    function automatic logic [10:0] mrrs_to_dw(input logic [2:0] code);
        logic [2:0] c;
        c = (code > 3'd5) ? 3'd5 : code;
        return 11'd32 << c;
    endfunction

endpackage

// File: rtl/dma_read_requester_if.sv
// Command, RQ-formatter request and RC-parser descriptor signals of the DMA read requester.
// master = requester side, slave = user logic / pcie_interface side.
interface dma_read_requester_if #(
    parameter int unsigned LEN_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [63:0]          cmd_addr;
    logic [LEN_WIDTH-1:0] cmd_len;

    logic                 rq_valid;
    logic                 rq_ready;
    logic [3:0]           rq_type;
    logic                 rq_sop;
    logic                 rq_last;
    logic [63:0]          rq_addr;
    logic [10:0]          rq_dword_count;
    logic [7:0]           rq_tag;
    logic [15:0]          rq_requester_id;
    logic [2:0]           rq_tc;

    logic                 rc_desc_valid;
    logic [7:0]           rc_tag;
    logic [2:0]           rc_status;
    logic                 rc_request_completed;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output rq_valid, rq_type, rq_sop, rq_last, rq_addr, rq_dword_count, rq_tag,
        output rq_requester_id, rq_tc,
        input  rq_ready,
        input  rc_desc_valid, rc_tag, rc_status, rc_request_completed
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  rq_valid, rq_type, rq_sop, rq_last, rq_addr, rq_dword_count, rq_tag,
        input  rq_requester_id, rq_tc,
        output rq_ready,
        output rc_desc_valid, rc_tag, rc_status, rc_request_completed
    );

endinterface

// File: rtl/dma_tag_pool.sv
// Tag allocator: in-use bitmap, lowest-free-tag priority encoder, outstanding counter.
// Release is qualified internally (tag in range and in use); flush frees every tag.
module dma_tag_pool #(
    parameter int unsigned TAG_COUNT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    output logic       alloc_avail,
    output logic [7:0] alloc_tag,
    input  logic [7:0] query_tag,
    output logic       query_in_use,
    input  logic       release_req,
    input  logic       flush,
    output logic [8:0] outstanding
);

    logic [TAG_COUNT-1:0] in_use_q, in_use_d;
    logic [8:0]           outstanding_q, outstanding_d;
    logic                 do_alloc, do_release;

    always_comb begin
        alloc_avail = 1'b0;
        alloc_tag   = '0;
        for (int i = int'(TAG_COUNT) - 1; i >= 0; i--) begin
            if (!in_use_q[i]) begin
                alloc_avail = 1'b1;
                alloc_tag   = 8'(i);
            end
        end
    end

    // Out-of-range tags never match any bitmap entry, so they read as free.
    always_comb begin
        query_in_use = 1'b0;
        for (int i = 0; i < int'(TAG_COUNT); i++) begin
            if (query_tag == 8'(i)) query_in_use = in_use_q[i];
        end
    end

    assign do_alloc   = alloc && alloc_avail;
    assign do_release = release_req && query_in_use;

    always_comb begin
        in_use_d = in_use_q;
        for (int i = 0; i < int'(TAG_COUNT); i++) begin
            if (do_alloc && alloc_tag == 8'(i))     in_use_d[i] = 1'b1;
            if (do_release && query_tag == 8'(i))   in_use_d[i] = 1'b0;
        end
        if (flush) in_use_d = '0;
    end

    always_comb begin
        outstanding_d = outstanding_q + 9'(do_alloc) - 9'(do_release);
        if (flush) outstanding_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_use_q      <= '0;
            outstanding_q <= '0;
        end else begin
            in_use_q      <= in_use_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding = outstanding_q;

endmodule

// File: rtl/dma_read_requester.sv
// Splits a host read command into MRd requests bounded by MRRS and 4 KB pages, tracking tags.
// Optional completion timeout enabled by defining DMA_RD_TIMEOUT_EN.
module dma_read_requester
    import venturi_pcie_pkg::*;
#(
    parameter int unsigned TAG_COUNT      = 32,
    parameter int unsigned LEN_WIDTH      = 16,
    parameter logic [2:0]  TC             = 3'd0,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dma_read_requester_if.master        bus,
    input  logic [2:0]                  cfg_max_read_req,
    input  logic [15:0]                 requester_id,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [8:0]                  outstanding
);

    rd_state_e            state_q;
    logic [63:0]          addr_q;
    logic [LEN_WIDTH-1:0] rem_q;
    logic                 rq_valid_q;
    logic [63:0]          rq_addr_q;
    logic [10:0]          rq_dword_count_q;
    logic [7:0]           rq_tag_q;
    logic [15:0]          rq_requester_id_q;
    logic [2:0]           rq_tc_q;
    logic                 done_q;
    logic                 err_q;

    logic                 alloc_avail;
    logic [7:0]           alloc_tag;
    logic                 tag_in_use;
    logic                 cpl_hit;
    logic                 timeout;
    logic [10:0]          mrrs_dw;
    logic [10:0]          page_left;
    logic [10:0]          chunk;
    logic [31:0]          rem_ext;

    assign mrrs_dw   = mrrs_to_dw(cfg_max_read_req);
    assign page_left = 11'(PAGE_DW) - {1'b0, addr_q[11:2]};
    assign rem_ext   = 32'(rem_q);

    always_comb begin
        chunk = mrrs_dw;
        if (page_left < chunk)       chunk = page_left;
        if (rem_ext < 32'(chunk))    chunk = rem_ext[10:0];
    end

    assign cpl_hit = bus.rc_desc_valid && tag_in_use;

    dma_tag_pool #(
        .TAG_COUNT(TAG_COUNT)
    ) u_tag_pool (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (state_q == StAlloc && !timeout),
        .alloc_avail (alloc_avail),
        .alloc_tag   (alloc_tag),
        .query_tag   (bus.rc_tag),
        .query_in_use(tag_in_use),
        .release_req (bus.rc_desc_valid && bus.rc_request_completed),
        .flush       (timeout),
        .outstanding (outstanding)
    );

`ifdef DMA_RD_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        tmo_reload;

    assign tmo_reload = cpl_hit || (state_q == StIssue && bus.rq_ready);
    assign timeout    = (outstanding != '0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (tmo_reload || timeout || outstanding == '0) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            rem_q             <= '0;
            rq_valid_q        <= 1'b0;
            rq_addr_q         <= '0;
            rq_dword_count_q  <= '0;
            rq_tag_q          <= '0;
            rq_requester_id_q <= '0;
            rq_tc_q           <= '0;
            done_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cpl_hit && bus.rc_status != CPL_STATUS_SC) err_q <= 1'b1;
            if (timeout) begin
                err_q      <= 1'b1;
                rq_valid_q <= 1'b0;
                state_q    <= StDrain;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.cmd_valid) begin
                            addr_q  <= bus.cmd_addr & ~64'h3;
                            rem_q   <= bus.cmd_len;
                            err_q   <= 1'b0;
                            state_q <= (bus.cmd_len == '0) ? StDrain : StAlloc;
                        end
                    end
                    StAlloc: begin
                        if (alloc_avail) begin
                            rq_valid_q        <= 1'b1;
                            rq_addr_q         <= addr_q;
                            rq_dword_count_q  <= chunk;
                            rq_tag_q          <= alloc_tag;
                            rq_requester_id_q <= requester_id;
                            rq_tc_q           <= TC;
                            state_q           <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (bus.rq_ready) begin
                            rq_valid_q <= 1'b0;
                            addr_q     <= addr_q + {51'b0, rq_dword_count_q, 2'b00};
                            rem_q      <= rem_q - LEN_WIDTH'(rq_dword_count_q);
                            state_q    <= (rem_q == LEN_WIDTH'(rq_dword_count_q)) ? StDrain
                                                                                  : StAlloc;
                        end
                    end
                    StDrain: begin
                        if (outstanding == '0) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.cmd_ready       = (state_q == StIdle);
    assign bus.rq_valid        = rq_valid_q;
    assign bus.rq_type         = RQ_TYPE_MRD;
    assign bus.rq_sop          = rq_valid_q;
    assign bus.rq_last         = rq_valid_q;
    assign bus.rq_addr         = rq_addr_q;
    assign bus.rq_dword_count  = rq_dword_count_q;
    assign bus.rq_tag          = rq_tag_q;
    assign bus.rq_requester_id = rq_requester_id_q;
    assign bus.rq_tc           = rq_tc_q;

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dma_read_requester.sv
// Directed bench for dma_read_requester: a 32-tag instance for most scenarios and a
// 2-tag instance for tag exhaustion.
module tb_dma_read_requester;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_read_requester_if #(.LEN_WIDTH(16)) bus  ();
    dma_read_requester_if #(.LEN_WIDTH(16)) bus2 ();

    logic [2:0]  mrrs;
    logic [15:0] req_id;
    logic        busy, done, err;
    logic [8:0]  outstanding;
    logic        busy2, done2, err2;
    logic [8:0]  outstanding2;

    int checks = 0;
    int failures = 0;

    dma_read_requester #(
        .TAG_COUNT(32), .LEN_WIDTH(16), .TC(3'd0), .TIMEOUT_CYCLES(65536)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cfg_max_read_req(mrrs),
        .requester_id(req_id), .busy(busy), .done(done), .err(err), .outstanding(outstanding)
    );

    dma_read_requester #(
        .TAG_COUNT(2), .LEN_WIDTH(16), .TC(3'd0), .TIMEOUT_CYCLES(65536)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .cfg_max_read_req(mrrs),
        .requester_id(req_id), .busy(busy2), .done(done2), .err(err2),
        .outstanding(outstanding2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [15:0] len, input logic [2:0] m);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        mrrs          = m;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic accept_rq(output logic [63:0] a, output logic [10:0] n,
                             output logic [7:0] t, output bit ok);
        ok = 1'b0; a = '0; n = '0; t = '0;
        bus.rq_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.rq_valid) begin
                a = bus.rq_addr; n = bus.rq_dword_count; t = bus.rq_tag; ok = 1'b1;
            end
            tick();
        end
        bus.rq_ready = 1'b0;
    endtask

    task automatic accept_rq2(output logic [63:0] a, output logic [7:0] t, output bit ok);
        ok = 1'b0; a = '0; t = '0;
        bus2.rq_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus2.rq_valid) begin
                a = bus2.rq_addr; t = bus2.rq_tag; ok = 1'b1;
            end
            tick();
        end
        bus2.rq_ready = 1'b0;
    endtask

    task automatic complete(input logic [7:0] tag, input logic [2:0] st);
        bus.rc_desc_valid = 1'b1; bus.rc_tag = tag; bus.rc_status = st;
        bus.rc_request_completed = 1'b1;
        tick();
        bus.rc_desc_valid = 1'b0; bus.rc_request_completed = 1'b0; bus.rc_status = '0;
    endtask

    task automatic complete2(input logic [7:0] tag);
        bus2.rc_desc_valid = 1'b1; bus2.rc_tag = tag; bus2.rc_status = '0;
        bus2.rc_request_completed = 1'b1;
        tick();
        bus2.rc_desc_valid = 1'b0; bus2.rc_request_completed = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
        end
        checks++;
        if ({bus.rq_valid, bus.rq_sop, bus.rq_last, busy, done, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.rq_valid, bus.rq_sop, bus.rq_last, busy, done, err});
        end
        checks++;
        if (outstanding !== 9'd0 || bus.rq_tag !== 8'd0 || bus.rq_dword_count !== 11'd0) begin
            failures++;
            $display("FAIL reset_counts: got out=%0d tag=%0d dw=%0d want 0 0 0",
                     outstanding, bus.rq_tag, bus.rq_dword_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mrrs_split();
        logic [63:0] a; logic [10:0] n; logic [7:0] t; bit ok;
        send_cmd(64'h1000, 16'd64, 3'd0);
        accept_rq(a, n, t, ok);
        checks++;
        if (!ok || a !== 64'h1000 || n !== 11'd32 || t !== 8'd0) begin
            failures++;
            $display("FAIL split_rq0: got ok=%b %h/%0d/%0d want 1 1000/32/0", ok, a, n, t);
        end
        checks++;
        if (bus.rq_requester_id !== 16'hBEEF || bus.rq_tc !== 3'd0 || bus.rq_type !== 4'd0) begin
            failures++;
            $display("FAIL split_fields: got id=%h tc=%0d type=%0d want beef 0 0",
                     bus.rq_requester_id, bus.rq_tc, bus.rq_type);
        end
        accept_rq(a, n, t, ok);
        checks++;
        if (!ok || a !== 64'h1080 || n !== 11'd32 || t !== 8'd1) begin
            failures++;
            $display("FAIL split_rq1: got ok=%b %h/%0d/%0d want 1 1080/32/1", ok, a, n, t);
        end
        checks++;
        if (outstanding !== 9'd2 || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL split_inflight: got out=%0d busy=%b rdy=%b want 2 1 0",
                     outstanding, busy, bus.cmd_ready);
        end
        complete(8'd0, 3'd0);
        complete(8'd1, 3'd0);
        wait_done(ok);
        checks++;
        if (!ok || outstanding !== 9'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL split_done: got done=%b out=%0d err=%b want 1 0 0",
                     ok, outstanding, err);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL split_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_4k_split();
        logic [63:0] a; logic [10:0] n; logic [7:0] t; bit ok;
        send_cmd(64'h1F80, 16'd64, 3'd5);
        accept_rq(a, n, t, ok);
        checks++;
        if (!ok || a !== 64'h1F80 || n !== 11'd32 || t !== 8'd0) begin
            failures++;
            $display("FAIL 4k_rq0: got ok=%b %h/%0d/%0d want 1 1f80/32/0", ok, a, n, t);
        end
        accept_rq(a, n, t, ok);
        checks++;
        if (!ok || a !== 64'h2000 || n !== 11'd32 || t !== 8'd1) begin
            failures++;
            $display("FAIL 4k_rq1: got ok=%b %h/%0d/%0d want 1 2000/32/1", ok, a, n, t);
        end
        complete(8'd1, 3'd0);
        complete(8'd0, 3'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL 4k_done: got no done want done");
        end
    endtask

    task automatic test_ready_stall();
        logic [63:0] a; logic [10:0] n; logic [7:0] t; bit ok;
        send_cmd(64'h0, 16'd16, 3'd0);
        bus.rq_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rq_valid !== 1'b1 || bus.rq_addr !== 64'h0 ||
                bus.rq_dword_count !== 11'd16 || bus.rq_tag !== 8'd0) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b %h/%0d/%0d want 1 0/16/0", i,
                         bus.rq_valid, bus.rq_addr, bus.rq_dword_count, bus.rq_tag);
            end
            tick();
        end
        accept_rq(a, n, t, ok);
        checks++;
        if (!ok || a !== 64'h0 || n !== 11'd16 || t !== 8'd0) begin
            failures++;
            $display("FAIL stall_rq: got ok=%b %h/%0d/%0d want 1 0/16/0", ok, a, n, t);
        end
        bus.rq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.rq_valid !== 1'b0) begin
                failures++; $display("FAIL stall_extra%0d: got rq_valid=1 want 0", i);
            end
            tick();
        end
        bus.rq_ready = 1'b0;
        complete(8'd0, 3'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL stall_done: got no done want done");
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a; logic [10:0] n; logic [7:0] t; bit ok;
        send_cmd(64'h3000, 16'd64, 3'd0);
        accept_rq(a, n, t, ok);
        // tag1 allocation and tag0 release land on the same edge
        complete(8'd0, 3'd0);
        checks++;
        if (outstanding !== 9'd1 || bus.rq_valid !== 1'b1 || bus.rq_tag !== 8'd1 ||
            bus.rq_addr !== 64'h3080) begin
            failures++;
            $display("FAIL b2b_swap: got out=%0d v=%b tag=%0d addr=%h want 1 1 1 3080",
                     outstanding, bus.rq_valid, bus.rq_tag, bus.rq_addr);
        end
        accept_rq(a, n, t, ok);
        complete(8'd1, 3'd0);
        wait_done(ok);
        checks++;
        if (!ok || outstanding !== 9'd0) begin
            failures++;
            $display("FAIL b2b_done: got done=%b out=%0d want 1 0", ok, outstanding);
        end
    endtask

    task automatic test_error_and_zero_len();
        logic [63:0] a; logic [10:0] n; logic [7:0] t; bit ok;
        send_cmd(64'h4000, 16'd8, 3'd0);
        accept_rq(a, n, t, ok);
        complete(8'd0, 3'b001);
        checks++;
        if (err !== 1'b1 || outstanding !== 9'd0) begin
            failures++;
            $display("FAIL err_set: got err=%b out=%0d want 1 0", err, outstanding);
        end
        wait_done(ok);
        checks++;
        if (!ok || err !== 1'b1) begin
            failures++; $display("FAIL err_done: got done=%b err=%b want 1 1", ok, err);
        end
        tick();
        send_cmd(64'h5000, 16'd0, 3'd0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || bus.rq_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_accept: got err=%b busy=%b v=%b done=%b want 0 1 0 0",
                     err, busy, bus.rq_valid, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || bus.rq_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: got done=%b v=%b rdy=%b want 1 0 1",
                     done, bus.rq_valid, bus.cmd_ready);
        end
        complete(8'd7, 3'b001);
        checks++;
        if (outstanding !== 9'd0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stray_cpl: got out=%0d err=%b busy=%b want 0 0 0",
                     outstanding, err, busy);
        end
    endtask

    task automatic test_tag_exhaust();
        logic [63:0] a; logic [7:0] t; bit ok;
        bus2.cmd_valid = 1'b1; bus2.cmd_addr = 64'h0; bus2.cmd_len = 16'd128; mrrs = 3'd0;
        tick();
        bus2.cmd_valid = 1'b0;
        accept_rq2(a, t, ok);
        checks++;
        if (!ok || a !== 64'h0 || t !== 8'd0) begin
            failures++; $display("FAIL ex_rq0: got ok=%b %h/%0d want 1 0/0", ok, a, t);
        end
        accept_rq2(a, t, ok);
        checks++;
        if (!ok || a !== 64'h80 || t !== 8'd1) begin
            failures++; $display("FAIL ex_rq1: got ok=%b %h/%0d want 1 80/1", ok, a, t);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus2.rq_valid !== 1'b0 || outstanding2 !== 9'd2 || busy2 !== 1'b1) begin
                failures++;
                $display("FAIL ex_stall%0d: got v=%b out=%0d busy=%b want 0 2 1", i,
                         bus2.rq_valid, outstanding2, busy2);
            end
        end
        complete2(8'd0);
        checks++;
        if (bus2.rq_valid !== 1'b0 || outstanding2 !== 9'd1) begin
            failures++;
            $display("FAIL ex_rel_cycle: got v=%b out=%0d want 0 1", bus2.rq_valid, outstanding2);
        end
        tick();
        checks++;
        if (bus2.rq_valid !== 1'b1 || bus2.rq_tag !== 8'd0 || bus2.rq_addr !== 64'h100) begin
            failures++;
            $display("FAIL ex_reissue0: got v=%b tag=%0d addr=%h want 1 0 100",
                     bus2.rq_valid, bus2.rq_tag, bus2.rq_addr);
        end
        accept_rq2(a, t, ok);
        complete2(8'd1);
        tick();
        checks++;
        if (bus2.rq_valid !== 1'b1 || bus2.rq_tag !== 8'd1 || bus2.rq_addr !== 64'h180) begin
            failures++;
            $display("FAIL ex_reissue1: got v=%b tag=%0d addr=%h want 1 1 180",
                     bus2.rq_valid, bus2.rq_tag, bus2.rq_addr);
        end
        accept_rq2(a, t, ok);
        complete2(8'd0);
        complete2(8'd1);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (done2) ok = 1'b1;
        end
        checks++;
        if (!ok || outstanding2 !== 9'd0) begin
            failures++;
            $display("FAIL ex_done: got done=%b out=%0d want 1 0", ok, outstanding2);
        end
    endtask

    task automatic test_reset_mid_issue();
        send_cmd(64'h6000, 16'd16, 3'd0);
        bus.rq_ready = 1'b0;
        tick();
        checks++;
        if (bus.rq_valid !== 1'b1 || outstanding !== 9'd1) begin
            failures++;
            $display("FAIL rst_pre: got v=%b out=%0d want 1 1", bus.rq_valid, outstanding);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rq_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || outstanding !== 9'd0 ||
            busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got v=%b rdy=%b out=%0d busy=%b want 0 1 0 0",
                     bus.rq_valid, bus.cmd_ready, outstanding, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        complete(8'd0, 3'b001);
        checks++;
        if (outstanding !== 9'd0 || err !== 1'b0 || bus.rq_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_late_cpl: got out=%0d err=%b v=%b want 0 0 0",
                     outstanding, err, bus.rq_valid);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.rq_ready = 1'b0;
        bus.rc_desc_valid = 1'b0; bus.rc_tag = '0; bus.rc_status = '0;
        bus.rc_request_completed = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_addr = '0; bus2.cmd_len = '0; bus2.rq_ready = 1'b0;
        bus2.rc_desc_valid = 1'b0; bus2.rc_tag = '0; bus2.rc_status = '0;
        bus2.rc_request_completed = 1'b0;
        mrrs = 3'd0;
        req_id = 16'hBEEF;

        test_reset();
        test_mrrs_split();
        test_4k_split();
        test_ready_stall();
        test_back_to_back();
        test_error_and_zero_len();
        test_tag_exhaust();
        test_reset_mid_issue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
